// File: rtl/lsu_pkg.sv
// Shared LSU definitions: DCache micro-op codes, LDM/STM addressing modes and
// the multi-transfer sequencer state encoding.
package lsu_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LIST_W = 16;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned UOP_W  = 5;

  localparam logic [UOP_W-1:0] LSU_UOP_NOP = 5'b00000;
  localparam logic [UOP_W-1:0] LSU_UOP_STR = 5'b01001;
  localparam logic [UOP_W-1:0] LSU_UOP_LDR = 5'b01010;

  typedef enum logic [1:0] {
    MODE_DA = 2'b00,
    MODE_IA = 2'b01,
    MODE_DB = 2'b10,
    MODE_IB = 2'b11
  } ldm_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_XFER   = 2'd1,
    ST_FINISH = 2'd2
  } seq_state_e;

  // Increment modes (IA/IB) move the base upwards.
  function automatic logic mode_is_inc(input logic [1:0] mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/ldm_stm_sequencer_popcount16.sv
// Population count of a 16-bit register list.
module popcount16
  import lsu_pkg::*;
(
  input  logic [LIST_W-1:0] bits,
  output logic [CNT_W-1:0]  count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < 16; i++) begin
      count = count + CNT_W'(bits[i]);
    end
  end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM micro-sequencer: expands a register list into one DCache transfer per cycle.
// Optional base writeback is built only with LDM_STM_WRITEBACK_EN defined.
module ldm_stm_sequencer
  import lsu_pkg::*;
#(
  parameter logic [4:0] UOP_STR = LSU_UOP_STR,
  parameter logic [4:0] UOP_LDR = LSU_UOP_LDR,
  parameter logic [4:0] UOP_NOP = LSU_UOP_NOP
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        is_load,
  input  logic [31:0] base,
  input  logic [15:0] reg_list,
  input  logic [1:0]  mode,
  input  logic        writeback,
  output logic        ready,
  output logic        done,
  output logic [31:0] cache_addr,
  output logic [4:0]  cache_uop,
  output logic [31:0] cache_wdata,
  input  logic [31:0] cache_rdata,
  output logic [3:0]  rf_rd_idx,
  input  logic [31:0] rf_rd_data,
  output logic        rf_we,
  output logic [3:0]  rf_wr_idx,
  output logic [31:0] rf_wr_data,
  output logic        base_wb_en,
  output logic [31:0] base_wb_value
);

  seq_state_e          state_q, state_d;
  logic                is_load_q;
  logic [LIST_W-1:0]   list_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                ld_pend_q;
  logic [IDX_W-1:0]    ld_idx_q;

  logic [CNT_W-1:0]    n_regs;
  logic [ADDR_W-1:0]   four_n;
  logic [ADDR_W-1:0]   start_addr;
  logic [IDX_W-1:0]    cur_idx;
  logic                last_xfer;
  logic                accept;
  logic                wb_hit;
  logic [ADDR_W-1:0]   wb_val;

  popcount16 u_popcount (
    .bits  (reg_list),
    .count (n_regs)
  );

  assign accept    = start && (state_q == ST_IDLE);
  assign four_n    = ADDR_W'({n_regs, 2'b00});
  assign last_xfer = (list_q & (list_q - 16'd1)) == '0;

  // First word address of the block for each addressing mode.
  always_comb begin
    start_addr = base;
    case (mode)
      MODE_DA: start_addr = base - four_n + 32'd4;
      MODE_IA: start_addr = base;
      MODE_DB: start_addr = base - four_n;
      MODE_IB: start_addr = base + 32'd4;
      default: start_addr = base;
    endcase
  end

  // Lowest remaining register is transferred next.
  always_comb begin
    cur_idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (list_q[i]) cur_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = (reg_list == '0) ? ST_FINISH : ST_XFER;
      ST_XFER:   if (last_xfer) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      is_load_q <= 1'b0;
      list_q    <= '0;
      addr_q    <= '0;
      ld_pend_q <= 1'b0;
      ld_idx_q  <= '0;
    end else begin
      ld_pend_q <= 1'b0;
      if (accept) begin
        is_load_q <= is_load;
        list_q    <= reg_list;
        addr_q    <= start_addr;
      end else if (state_q == ST_XFER) begin
        list_q    <= list_q & ~(16'd1 << cur_idx);
        addr_q    <= addr_q + 32'd4;
        ld_pend_q <= is_load_q;
        ld_idx_q  <= cur_idx;
      end
    end
  end

`ifdef LDM_STM_WRITEBACK_EN
  logic              wb_q;
  logic [ADDR_W-1:0] wb_value_q;

  // Writeback is dropped for an empty list so no base update is signalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_q       <= 1'b0;
      wb_value_q <= '0;
    end else if (accept) begin
      wb_q       <= writeback && (reg_list != '0);
      wb_value_q <= mode_is_inc(mode) ? (base + four_n) : (base - four_n);
    end
  end

  assign wb_hit = wb_q;
  assign wb_val = wb_value_q;
`else
  logic unused_writeback;
  assign unused_writeback = writeback;
  assign wb_hit = 1'b0;
  assign wb_val = '0;
`endif

  always_comb begin
    ready         = 1'b0;
    done          = 1'b0;
    cache_addr    = '0;
    cache_uop     = UOP_NOP;
    cache_wdata   = '0;
    rf_rd_idx     = '0;
    rf_we         = 1'b0;
    rf_wr_idx     = '0;
    rf_wr_data    = '0;
    base_wb_en    = 1'b0;
    base_wb_value = '0;
    // Load data returns one cycle after its LDR, independent of FSM state.
    if (ld_pend_q) begin
      rf_we      = 1'b1;
      rf_wr_idx  = ld_idx_q;
      rf_wr_data = cache_rdata;
    end
    case (state_q)
      ST_IDLE: ready = 1'b1;
      ST_XFER: begin
        cache_addr = addr_q;
        if (is_load_q) begin
          cache_uop = UOP_LDR;
        end else begin
          cache_uop   = UOP_STR;
          rf_rd_idx   = cur_idx;
          cache_wdata = rf_rd_data;
        end
      end
      ST_FINISH: begin
        done = 1'b1;
        if (wb_hit) begin
          base_wb_en    = 1'b1;
          base_wb_value = wb_val;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer with register-file and DCache models.
module tb_ldm_stm_sequencer;
  import lsu_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        start, is_load, writeback;
  logic [31:0] base;
  logic [15:0] reg_list;
  logic [1:0]  mode;
  logic        ready, done;
  logic [31:0] cache_addr, cache_wdata, cache_rdata;
  logic [4:0]  cache_uop;
  logic [3:0]  rf_rd_idx, rf_wr_idx;
  logic [31:0] rf_rd_data, rf_wr_data;
  logic        rf_we, base_wb_en;
  logic [31:0] base_wb_value;

  logic [31:0] rf [16];
  logic [31:0] mem [4096];
  logic        init_env;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  assign rf_rd_data = rf[rf_rd_idx];

  ldm_stm_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .is_load       (is_load),
    .base          (base),
    .reg_list      (reg_list),
    .mode          (mode),
    .writeback     (writeback),
    .ready         (ready),
    .done          (done),
    .cache_addr    (cache_addr),
    .cache_uop     (cache_uop),
    .cache_wdata   (cache_wdata),
    .cache_rdata   (cache_rdata),
    .rf_rd_idx     (rf_rd_idx),
    .rf_rd_data    (rf_rd_data),
    .rf_we         (rf_we),
    .rf_wr_idx     (rf_wr_idx),
    .rf_wr_data    (rf_wr_data),
    .base_wb_en    (base_wb_en),
    .base_wb_value (base_wb_value)
  );

  // Register file and DCache environment (word-indexed by addr[13:2]).
  always @(posedge clock) begin
    if (init_env) begin
      for (int i = 0; i < 16; i++) rf[i] <= 32'h0;
      rf[1] <= 32'h11;
      rf[2] <= 32'h22;
      mem[12'h1F8 >> 2] <= 32'hA;
      mem[12'h1FC >> 2] <= 32'hB;
      for (int i = 0; i < 4; i++) begin
        mem[(32'h3F4 >> 2) + i]  <= 32'h40 + 32'(i);
        mem[(32'h2000 >> 2) + i] <= 32'h900 + 32'(i);
      end
      for (int i = 0; i < 16; i++) mem[(32'h1000 >> 2) + i] <= 32'h500 + 32'(i);
      cache_rdata <= 32'h0;
    end else begin
      if (cache_uop == LSU_UOP_LDR) cache_rdata <= mem[cache_addr[13:2]];
      if (cache_uop == LSU_UOP_STR) mem[cache_addr[13:2]] <= cache_wdata;
      if (rf_we) rf[rf_wr_idx] <= rf_wr_data;
    end
  end

  typedef struct {
    logic        is_load;
    logic [31:0] base;
    logic [15:0] reg_list;
    logic [1:0]  mode;
    logic        wb;
    int          hold;
    int          exp_done;
    int          exp_uops;
    logic [31:0] exp_first_addr;
    logic [31:0] exp_last_addr;
    logic [31:0] exp_first_data;
    int          exp_we;
    logic [31:0] exp_wb_value;
    logic        chk_en;
    logic [31:0] chk_key;
    logic [31:0] chk_val;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int uops, wes, wbs, dones, done_cyc, ready_cyc, exp_wbs;
    logic [31:0] first_addr, last_addr, first_data, wb_val;
    logic bad_uop, rdy0;
    string p;
    p = $sformatf("v%0d", idx);
    uops = 0; wes = 0; wbs = 0; dones = 0; done_cyc = -1; ready_cyc = -1;
    first_addr = 0; last_addr = 0; first_data = 0; wb_val = 0; bad_uop = 1'b0;
`ifdef LDM_STM_WRITEBACK_EN
    exp_wbs = (v.wb && v.reg_list != 16'h0) ? 1 : 0;
`else
    exp_wbs = 0;
`endif
    @(posedge clock); #1;
    is_load = v.is_load; base = v.base; reg_list = v.reg_list;
    mode = v.mode; writeback = v.wb; start = 1'b1;
    @(negedge clock);
    rdy0 = ready;
    @(posedge clock); #1;
    start = (v.hold > 0);
    is_load = ~v.is_load; base = ~v.base; reg_list = ~v.reg_list;
    mode = ~v.mode; writeback = ~v.wb;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (cache_uop != LSU_UOP_NOP) begin
        if (uops == 0) begin
          first_addr = cache_addr;
          if (!v.is_load) first_data = cache_wdata;
        end
        last_addr = cache_addr;
        uops++;
        if (cache_uop != (v.is_load ? LSU_UOP_LDR : LSU_UOP_STR)) bad_uop = 1'b1;
      end
      if (rf_we) begin
        if (wes == 0 && v.is_load) first_data = rf_wr_data;
        wes++;
      end
      if (done) begin
        if (done_cyc < 0) done_cyc = c;
        dones++;
      end
      if (base_wb_en) begin
        wbs++;
        wb_val = base_wb_value;
      end
      if (ready) begin
        ready_cyc = c;
        break;
      end
      @(posedge clock); #1;
      start = (c < v.hold);
    end
    start = 1'b0;
    check({p, " ready_at_request"}, 32'(rdy0), 32'd1);
    check({p, " done_cycle"}, 32'(done_cyc), 32'(v.exp_done));
    check({p, " done_pulses"}, 32'(dones), 32'd1);
    check({p, " ready_return_cycle"}, 32'(ready_cyc), 32'(v.exp_done + 1));
    check({p, " uop_count"}, 32'(uops), 32'(v.exp_uops));
    check({p, " uop_kind_error"}, 32'(bad_uop), 32'd0);
    check({p, " first_addr"}, first_addr, v.exp_first_addr);
    check({p, " last_addr"}, last_addr, v.exp_last_addr);
    check({p, " first_data"}, first_data, v.exp_first_data);
    check({p, " rf_we_count"}, 32'(wes), 32'(v.exp_we));
    check({p, " wb_en_count"}, 32'(wbs), 32'(exp_wbs));
    check({p, " wb_value"}, wb_val, (exp_wbs == 1) ? v.exp_wb_value : 32'h0);
    if (v.chk_en) begin
      check({p, " data_result"},
            v.is_load ? rf[v.chk_key[3:0]] : mem[v.chk_key[13:2]], v.chk_val);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h_uops, h_we, h_done;
    logic h_ready;

    //        ld   base          list      mode   wb  hold done uops first_addr    last_addr     first_data we  wb_value      chk  key      val
    vecs[0] = '{1'b0, 32'h100,      16'h0006, 2'b01, 1'b1, 0, 3,  2,  32'h100,      32'h104,      32'h11,    0,  32'h108,      1'b1, 32'h104, 32'h22};
    vecs[1] = '{1'b1, 32'h200,      16'h8001, 2'b10, 1'b1, 0, 3,  2,  32'h1F8,      32'h1FC,      32'hA,     2,  32'h1F8,      1'b1, 32'd15,  32'hB};
    vecs[2] = '{1'b0, 32'hFFFFFFFC, 16'h0001, 2'b11, 1'b1, 0, 2,  1,  32'h0,        32'h0,        32'hA,     0,  32'h0,        1'b1, 32'h0,   32'hA};
    vecs[3] = '{1'b0, 32'h300,      16'h0000, 2'b01, 1'b1, 0, 1,  0,  32'h0,        32'h0,        32'h0,     0,  32'h300,      1'b0, 32'h0,   32'h0};
    vecs[4] = '{1'b1, 32'h400,      16'h00F0, 2'b00, 1'b1, 0, 5,  4,  32'h3F4,      32'h400,      32'h40,    4,  32'h3F0,      1'b1, 32'd7,   32'h43};
    vecs[5] = '{1'b1, 32'h1000,     16'hFFFF, 2'b01, 1'b1, 0, 17, 16, 32'h1000,     32'h103C,     32'h500,   16, 32'h1040,     1'b1, 32'd15,  32'h50F};
    vecs[6] = '{1'b0, 32'h20,       16'h8000, 2'b10, 1'b0, 0, 2,  1,  32'h1C,       32'h1C,       32'h50F,   0,  32'h1C,       1'b1, 32'h1C,  32'h50F};
    vecs[7] = '{1'b0, 32'h4,        16'h0003, 2'b00, 1'b1, 0, 3,  2,  32'h0,        32'h4,        32'h500,   0,  32'hFFFFFFFC, 1'b1, 32'h4,   32'h501};
    vecs[8] = '{1'b0, 32'h600,      16'h000F, 2'b01, 1'b0, 3, 5,  4,  32'h600,      32'h60C,      32'h500,   0,  32'h610,      1'b1, 32'h60C, 32'h503};

    reset = 1'b1; init_env = 1'b1;
    start = 1'b0; is_load = 1'b0; base = 32'h0; reg_list = 16'h0; mode = 2'b00; writeback = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset ready", 32'(ready), 32'd1);
    check("reset done", 32'(done), 32'd0);
    check("reset rf_we", 32'(rf_we), 32'd0);
    check("reset base_wb_en", 32'(base_wb_en), 32'd0);
    check("reset cache_uop", 32'(cache_uop), 32'(LSU_UOP_NOP));
    check("reset cache_addr", cache_addr, 32'h0);
    check("reset cache_wdata", cache_wdata, 32'h0);
    check("reset rf_rd_idx", 32'(rf_rd_idx), 32'd0);
    check("reset rf_wr_idx", 32'(rf_wr_idx), 32'd0);
    check("reset rf_wr_data", rf_wr_data, 32'h0);
    check("reset base_wb_value", base_wb_value, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0; init_env = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Reset during cycle 2 of a 4-register LDM IA: R8 completes, R9..R11 must not.
    @(posedge clock); #1;
    is_load = 1'b1; base = 32'h2000; reg_list = 16'h0F00; mode = 2'b01; writeback = 1'b1; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    check("abort cycle2 rf_we", 32'(rf_we), 32'd1);
    check("abort cycle2 uop", 32'(cache_uop), 32'(LSU_UOP_LDR));
    @(posedge clock); #1;
    reset = 1'b0;
    h_uops = 0; h_we = 0; h_done = 0; h_ready = 1'b1;
    for (int c = 3; c < 9; c++) begin
      @(negedge clock);
      if (cache_uop != LSU_UOP_NOP) h_uops++;
      if (rf_we) h_we++;
      if (done) h_done++;
      if (!ready) h_ready = 1'b0;
    end
    check("abort uops_after_reset", 32'(h_uops), 32'd0);
    check("abort rf_we_after_reset", 32'(h_we), 32'd0);
    check("abort done_after_reset", 32'(h_done), 32'd0);
    check("abort ready_after_reset", 32'(h_ready), 32'd1);
    check("abort r8_loaded", rf[8], 32'h900);
    check("abort r9_untouched", rf[9], 32'h509);
    check("abort r11_untouched", rf[11], 32'h50B);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
